// File: rtl/uart_bus_bridge_if.sv
// Bundle between the UART-driven bus bridge, the UART core and the peripheral bus.
// The master side is the bridge; the slave side is the UART core plus the responders.
interface uart_bus_bridge_if #(
    parameter int address_width = 16
);
    logic [7:0]               rx_data_i;
    logic                     rx_valid_i;
    logic [7:0]               tx_data_o;
    logic                     tx_valid_o;
    logic                     tx_ready_i;
    logic [address_width-1:0] address_o;
    logic [7:0]               data_o;
    logic                     rd_wr_o;
    logic [7:0]               data_i;
    logic                     take_controlr_i;
    logic                     take_controlw_i;
    logic                     busy_o;

    modport master (
        input  rx_data_i,
        input  rx_valid_i,
        input  tx_ready_i,
        input  data_i,
        input  take_controlr_i,
        input  take_controlw_i,
        output tx_data_o,
        output tx_valid_o,
        output address_o,
        output data_o,
        output rd_wr_o,
        output busy_o
    );

    modport slave (
        output rx_data_i,
        output rx_valid_i,
        output tx_ready_i,
        output data_i,
        output take_controlr_i,
        output take_controlw_i,
        input  tx_data_o,
        input  tx_valid_o,
        input  address_o,
        input  data_o,
        input  rd_wr_o,
        input  busy_o
    );
endinterface

// File: rtl/uart_bus_bridge.sv
// Serial command parser that performs single-byte reads/writes on the peripheral bus
// and returns an ack, data or error byte to the UART transmitter.
module uart_bus_bridge #(
    parameter int                     address_width = 16,
    parameter logic [address_width-1:0] IdleAddress = {address_width{1'b1}},
    parameter int                     BusTimeout    = 16,
    parameter int                     RxTimeout     = 1_000_000
) (
    input logic               clk_i,
    input logic               reset_i,
    uart_bus_bridge_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        CMD_ADDR_HI,
        CMD_ADDR_LO,
        CMD_DATA,
        BUS_REQ,
        BUS_WAIT,
        TX_HDR,
        TX_DATA
    } state_e;

    localparam int RxW  = $clog2(RxTimeout + 1);
    localparam int BusW = $clog2(BusTimeout + 1);

    localparam logic [7:0] CmdWrite = 8'h57;
    localparam logic [7:0] CmdRead  = 8'h52;
    localparam logic [7:0] RspAck   = 8'h4B;
    localparam logic [7:0] RspData  = 8'h44;
    localparam logic [7:0] RspErr   = 8'h45;

    state_e         state_q, state_d;
    logic           is_wr_q, is_wr_d;
    logic [15:0]    addr_q, addr_d;
    logic [7:0]     data_q, data_d;
    logic [7:0]     rdata_q, rdata_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           busy_q, busy_d;
    logic [RxW-1:0] rx_cnt_q, rx_cnt_d;
    logic [BusW-1:0] bus_cnt_q, bus_cnt_d;

    logic claim;
    logic rx_expired;
    logic bus_expired;
    logic in_cmd;

    assign claim       = is_wr_q ? bus.take_controlw_i : bus.take_controlr_i;
    assign rx_expired  = (rx_cnt_q == RxW'(RxTimeout - 1));
    assign bus_expired = (bus_cnt_q == BusW'(BusTimeout));
    assign in_cmd      = (state_q == CMD_ADDR_HI) || (state_q == CMD_ADDR_LO)
                      || (state_q == CMD_DATA);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            tx_data_q <= '0;
            busy_q    <= 1'b0;
            rx_cnt_q  <= '0;
            bus_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rdata_q   <= rdata_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
            rx_cnt_q  <= rx_cnt_d;
            bus_cnt_q <= bus_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.rx_valid_i &&
                    (bus.rx_data_i == CmdWrite || bus.rx_data_i == CmdRead))
                    state_d = CMD_ADDR_HI;
            end
            CMD_ADDR_HI: begin
                if (bus.rx_valid_i)  state_d = CMD_ADDR_LO;
                else if (rx_expired) state_d = IDLE;
            end
            CMD_ADDR_LO: begin
                if (bus.rx_valid_i)  state_d = is_wr_q ? CMD_DATA : BUS_REQ;
                else if (rx_expired) state_d = IDLE;
            end
            CMD_DATA: begin
                if (bus.rx_valid_i)  state_d = BUS_REQ;
                else if (rx_expired) state_d = IDLE;
            end
            BUS_REQ:  state_d = BUS_WAIT;
            BUS_WAIT: begin
                if (claim || bus_expired) state_d = TX_HDR;
            end
            TX_HDR: begin
                if (bus.tx_ready_i)
                    state_d = (tx_data_q == RspData) ? TX_DATA : IDLE;
            end
            TX_DATA: begin
                if (bus.tx_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        tx_data_d = tx_data_q;
        busy_d    = (state_d != IDLE);
        rx_cnt_d  = '0;
        bus_cnt_d = '0;

        if (in_cmd && !bus.rx_valid_i && state_d != IDLE)
            rx_cnt_d = rx_cnt_q + 1'b1;

        if (state_q == IDLE && bus.rx_valid_i)
            is_wr_d = (bus.rx_data_i == CmdWrite);

        // Two shifts leave {addr_hi, addr_lo} in big-endian order.
        if ((state_q == CMD_ADDR_HI || state_q == CMD_ADDR_LO) && bus.rx_valid_i)
            addr_d = {addr_q[7:0], bus.rx_data_i};

        if (state_q == CMD_DATA && bus.rx_valid_i)
            data_d = bus.rx_data_i;

        if (state_q == BUS_REQ)
            bus_cnt_d = BusW'(1);
        else if (state_q == BUS_WAIT && state_d == BUS_WAIT)
            bus_cnt_d = bus_cnt_q + 1'b1;

        if (state_q == BUS_WAIT) begin
            if (claim) begin
                tx_data_d = is_wr_q ? RspAck : RspData;
                if (!is_wr_q) rdata_d = bus.data_i;
            end else if (bus_expired) begin
                tx_data_d = RspErr;
            end
        end

        if (state_q == TX_HDR && state_d == TX_DATA)
            tx_data_d = rdata_q;
    end

    // Idle address must be present on every non-request cycle: responders act on address match.
    always_comb begin
        bus.address_o  = IdleAddress;
        bus.rd_wr_o    = 1'b0;
        if (state_q == BUS_REQ) begin
            bus.address_o = addr_q[address_width-1:0];
            bus.rd_wr_o   = is_wr_q;
        end
        bus.data_o     = data_q;
        bus.tx_valid_o = (state_q == TX_HDR) || (state_q == TX_DATA);
        bus.tx_data_o  = tx_data_q;
        bus.busy_o     = busy_q;
    end
endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

Bus initiator driven by a serial command stream: parses command bytes from a byte-level UART core, performs single-byte reads and writes on the shared 8-bit peripheral bus, and returns an acknowledge, data or error byte to the UART transmitter. It sits between the UART core and the peripheral bus, in parallel with the CPU, so a host PC can poke registers without firmware. Each access drives a one-cycle address/strobe and waits for the responders' `take_control` flags.

## Interface
- `address_width`, 16: bus address width, 1..16.
- `IdleAddress`, {address_width{1'b1}}: address driven when no access is in progress; must be unmapped.
- `BusTimeout`, 16: cycles to wait for `take_control` before reporting an error, ≥2.
- `RxTimeout`, 1_000_000: idle cycles allowed between bytes of one command, ≥2.
- `clk_i`  in  1  single clock.
- `reset_i`  in  1  asynchronous, active-low reset.
- `rx_data_i`  in  8  received byte.
- `rx_valid_i`  in  1  one-cycle strobe, `rx_data_i` valid.
- `tx_data_o`  out  8  byte to transmit.
- `tx_valid_o`  out  1  `tx_data_o` valid; held until accepted.
- `tx_ready_i`  in  1  UART accepts the byte when `tx_valid_o` and `tx_ready_i` are both 1.
- `address_o`  out  address_width  bus address.
- `data_o`  out  8  bus write data.
- `rd_wr_o`  out  1  1 = write, 0 = read.
- `data_i`  in  8  OR of responder read data.
- `take_controlr_i`  in  1  OR of responder read-claim flags.
- `take_controlw_i`  in  1  OR of responder write-claim flags.
- `busy_o`  out  1  1 whenever the FSM is not in IDLE.

## Operation
- Commands:
  - Write: `0x57`, addr_hi, addr_lo, data.
  - Read: `0x52`, addr_hi, addr_lo.
  - The address is big-endian; `{addr_hi,addr_lo}` is truncated to the low `address_width` bits.
- Responses:
  - Write success: `0x4B`.
  - Read success: `0x44` followed by the data byte.
  - Timeout (either command): `0x45`.
- Unknown first byte: ignored; the FSM stays in IDLE.
- FSM states: IDLE → CMD_ADDR_HI → CMD_ADDR_LO → (write only) CMD_DATA → BUS_REQ → BUS_WAIT → TX_HDR → (read success only) TX_DATA → IDLE.
- Each `rx_valid_i` in IDLE, CMD_ADDR_HI, CMD_ADDR_LO or CMD_DATA advances the FSM one state.
- `rx_valid_i` in BUS_REQ, BUS_WAIT, TX_HDR or TX_DATA is dropped.
- Inter-byte timeout: in the CMD_* states a counter clears on each `rx_valid_i`. At `RxTimeout` cycles without a byte, the FSM returns to IDLE with no bus access and no response.
- BUS_REQ, exactly one cycle:
  - `address_o` = captured address.
  - `rd_wr_o` = 1 for write, 0 for read.
  - `data_o` = write data.
- Outside BUS_REQ: `address_o` = `IdleAddress`, `rd_wr_o` = 0. This is mandatory because responders act (e.g. FIFO pop) on every cycle in which their address is present.
- BUS_WAIT, claim and timeout:
  - A write completes on `take_controlw_i` = 1; a read completes on `take_controlr_i` = 1. The flag of the other direction is ignored.
  - On a read, `data_i` is captured in the same cycle as `take_controlr_i`.
  - The wait counter starts at 1 on BUS_WAIT entry. If no claim has arrived by count `BusTimeout`, the response is `0x45` and TX_DATA is skipped.
- TX_HDR / TX_DATA: `tx_valid_o` = 1 with a stable `tx_data_o` until the handshake cycle, then advance. Backpressure from `tx_ready_i` is unbounded.
- `data_o` holds its last value outside BUS_REQ.

## Timing
- Reset values (asynchronous, immediate on `reset_i` = 0, from any state): FSM = IDLE, `address_o` = `IdleAddress`, `data_o` = 0, `rd_wr_o` = 0, `tx_valid_o` = 0, `tx_data_o` = 0, `busy_o` = 0, all counters = 0.
- Bus cycle after the last command byte:
  - Cycle N: final `rx_valid_i`.
  - Cycle N+1: BUS_REQ, bus driven.
  - Cycle N+2: BUS_WAIT begins; a responder's registered `take_control` appears here.
  - Cycle N+3 at the earliest: `tx_valid_o` = 1 carrying the response header.
- Read data byte: presented the cycle after the header is accepted.
- `busy_o` is registered and equals (state ≠ IDLE).

## Test plan
- Write: rx `0x57,0x00,0x12,0xA5`; responder raises `take_controlw_i` in BUS_WAIT cycle 1 -> exactly one cycle with `address_o` = `0x0012`, `rd_wr_o` = 1, `data_o` = `0xA5`; tx `0x4B`.
- Read: rx `0x52,0x00,0x34`; responder returns `take_controlr_i` = 1 with `data_i` = `0x5C` -> `address_o` = `0x0034` for exactly one cycle with `rd_wr_o` = 0; tx `0x44`, then `0x5C`.
- Bus timeout, `BusTimeout` = 16, no claim: read of `0x7FFF` -> tx `0x45` only, no second bus cycle. Also check that a `take_controlw_i` arriving during a read is ignored and the result is still `0x45`.
- Partial command: rx `0x57,0x00`, then silence for `RxTimeout` cycles -> IDLE, `busy_o` = 0, no bus cycle. A subsequent rx `0x22` is ignored; then a full read command completes normally.
- Backpressure: `tx_ready_i` = 0 for 20 cycles during TX_HDR of a read -> `tx_valid_o` and `tx_data_o` stable, 3 injected rx bytes dropped, `busy_o` = 1. On release, tx `0x44` then the data byte.
- Reset mid-access: assert `reset_i` = 0 during BUS_WAIT -> all outputs at reset values within the same cycle, no response byte. After release, a write command behaves as in scenario 1.
